// File: rtl/detect_count_bcd.sv
// rtl/detect_count_bcd.sv - per-period BCD detection counter with last/best latch and display registers
module detect_count_bcd #(
    parameter bit          EDGE_DETECT = 1'b1,
    parameter logic [15:0] SAT_BCD     = 16'h9999
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       detector_out,
    input  logic       max_tick,
    input  logic       show_best,
    output logic [3:0] d3,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic       new_result,
    output logic       overflow
);

    logic        det_q;
    logic [15:0] live;
    logic [15:0] last;
    logic [15:0] best;
    logic        evt;
    logic        at_sat;
    logic [15:0] live_next;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        evt       = EDGE_DETECT ? (detector_out & ~det_q) : detector_out;
        at_sat    = (live == SAT_BCD);
        live_next = live;
        // live_next already includes an event landing on the period-end cycle
        if (evt && !at_sat) begin
            live_next = bcd_inc(live);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            det_q            <= 1'b0;
            live             <= 16'h0000;
            last             <= 16'h0000;
            best             <= 16'h0000;
            {d3, d2, d1, d0} <= 16'h0000;
            new_result       <= 1'b0;
            overflow         <= 1'b0;
        end else begin
            det_q      <= detector_out;
            new_result <= max_tick;
            if (evt && at_sat) begin
                overflow <= 1'b1;
            end
            if (max_tick) begin
                last <= live_next;
                live <= 16'h0000;
                // Valid BCD digits order the same as plain binary, MSD first
                if (live_next > best) begin
                    best <= live_next;
                end
            end else begin
                live <= live_next;
            end
            {d3, d2, d1, d0} <= show_best ? best : last;
        end
    end

endmodule

// File: tb/tb_detect_count_bcd.sv
// tb/tb_detect_count_bcd.sv - scoreboard bench for detect_count_bcd
module tb_detect_count_bcd;

    logic       clk = 1'b0;
    logic       reset;
    logic       det;
    logic       show_best;
    logic       mt_m, mt_l, mt_s;
    logic [3:0] m3, m2, m1, m0, l3, l2, l1, l0, s3, s2, s1, s0;
    logic       nr_m, nr_l, nr_s, ov_m, ov_l, ov_s;

    int checks = 0;
    int passes = 0;

    logic [15:0] q_m[$];
    logic [15:0] q_l[$];
    logic [15:0] q_s[$];
    logic        pend_m = 1'b0, pend_l = 1'b0, pend_s = 1'b0;

    always #5 clk = ~clk;

    detect_count_bcd dut_m (
        .clk(clk), .reset(reset), .detector_out(det), .max_tick(mt_m), .show_best(show_best),
        .d3(m3), .d2(m2), .d1(m1), .d0(m0), .new_result(nr_m), .overflow(ov_m)
    );

    detect_count_bcd #(.EDGE_DETECT(1'b0)) dut_l (
        .clk(clk), .reset(reset), .detector_out(det), .max_tick(mt_l), .show_best(show_best),
        .d3(l3), .d2(l2), .d1(l1), .d0(l0), .new_result(nr_l), .overflow(ov_l)
    );

    detect_count_bcd #(.SAT_BCD(16'h0010)) dut_s (
        .clk(clk), .reset(reset), .detector_out(det), .max_tick(mt_s), .show_best(show_best),
        .d3(s3), .d2(s2), .d1(s1), .d0(s0), .new_result(nr_s), .overflow(ov_s)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic stray(input string name);
        checks++;
        $display("FAIL %s: new_result with empty scoreboard (got 1 expected 0)", name);
    endtask

    // Digits are compared at N+2, one cycle after new_result is seen
    always @(negedge clk) begin
        if (pend_m) begin
            if (q_m.size() == 0) stray("result_main");
            else check("result_main", {m3, m2, m1, m0}, q_m.pop_front());
        end
        if (pend_l) begin
            if (q_l.size() == 0) stray("result_lvl");
            else check("result_lvl", {l3, l2, l1, l0}, q_l.pop_front());
        end
        if (pend_s) begin
            if (q_s.size() == 0) stray("result_sat");
            else check("result_sat", {s3, s2, s1, s0}, q_s.pop_front());
        end
        pend_m = nr_m;
        pend_l = nr_l;
        pend_s = nr_s;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int n);
        repeat (n) begin
            det = 1'b1;
            cyc(1);
            det = 1'b0;
            cyc(1);
        end
    endtask

    task automatic tick_m(input logic [15:0] exp);
        q_m.push_back(exp);
        mt_m = 1'b1;
        cyc(1);
        mt_m = 1'b0;
        cyc(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout expected finish)");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; det = 1'b0; show_best = 1'b0;
        mt_m = 1'b0; mt_l = 1'b0; mt_s = 1'b0;
        cyc(3);
        @(negedge clk);
        check("reset_digits", {m3, m2, m1, m0}, 16'h0000);
        check("reset_flags", {14'd0, nr_m, ov_m}, 16'h0000);
        cyc(1);
        reset = 1'b0;

        // 1: five separated pulses
        pulse(5);
        tick_m(16'h0005);
        show_best = 1'b1;
        cyc(1);
        @(negedge clk);
        check("t1_best", {m3, m2, m1, m0}, 16'h0005);
        cyc(1);
        show_best = 1'b0;

        // 2: held-high detector, edge vs level
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        det = 1'b1;
        cyc(10);
        det = 1'b0;
        q_m.push_back(16'h0001);
        q_l.push_back(16'h0010);
        mt_m = 1'b1; mt_l = 1'b1;
        cyc(1);
        mt_m = 1'b0; mt_l = 1'b0;
        cyc(3);

        // 3: best survives a lower period
        pulse(12);
        tick_m(16'h0012);
        pulse(7);
        tick_m(16'h0007);
        show_best = 1'b1;
        cyc(1);
        @(negedge clk);
        check("t3_best", {m3, m2, m1, m0}, 16'h0012);
        cyc(1);
        show_best = 1'b0;
        cyc(1);
        @(negedge clk);
        check("t3_last", {m3, m2, m1, m0}, 16'h0007);
        cyc(1);

        // 4: event on the tick cycle, then back-to-back ticks
        pulse(8);
        det = 1'b1; mt_m = 1'b1;
        q_m.push_back(16'h0009);
        cyc(1);
        det = 1'b0;
        q_m.push_back(16'h0000);
        cyc(1);
        mt_m = 1'b0;
        cyc(3);
        pulse(2);
        tick_m(16'h0002);

        // 5: carry chain through 0999
        pulse(1000);
        tick_m(16'h1000);
        @(negedge clk);
        check("t5_no_overflow", {15'd0, ov_m}, 16'h0000);
        cyc(1);

        // 5b: saturation at 0010
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        pulse(11);
        q_s.push_back(16'h0010);
        mt_s = 1'b1;
        cyc(1);
        mt_s = 1'b0;
        cyc(3);
        @(negedge clk);
        check("t5_sat_overflow", {15'd0, ov_s}, 16'h0001);
        check("t5_main_overflow", {15'd0, ov_m}, 16'h0000);
        cyc(1);

        // 6: reset mid-period
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        pulse(5);
        tick_m(16'h0005);
        show_best = 1'b1;
        cyc(2);
        pulse(42);
        reset = 1'b1;
        cyc(1);
        @(negedge clk);
        check("t6_reset_digits", {m3, m2, m1, m0}, 16'h0000);
        check("t6_reset_sat_ov", {15'd0, ov_s}, 16'h0000);
        cyc(1);
        reset = 1'b0;
        show_best = 1'b0;
        pulse(3);
        tick_m(16'h0003);
        cyc(2);

        check("queues_drained", 16'(q_m.size() + q_l.size() + q_s.size()), 16'h0000);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
